// File: rtl/alu_pipe.sv
// alu_pipe: buffered integer ALU. Issued ops wait in an in-order FIFO, execute
// one per cycle (RV32I ALU/compare, RV32M multiply) or on an iterative
// restoring divider, and each result is held on the CDB until it is granted.
module alu_pipe #(
    parameter int XLEN  = 32,
    parameter int ROB_W = 5,
    parameter int DEPTH = 4
) (
    input  logic                     clk_in,
    input  logic                     rst_in,
    input  logic                     rdy_in,
    input  logic                     _clear,
    input  logic                     _alu_valid,
    input  logic [ROB_W-1:0]         _alu_rob_id,
    input  logic [4:0]               _alu_op,
    input  logic [XLEN-1:0]          _alu_v1,
    input  logic [XLEN-1:0]          _alu_v2,
    output logic                     _alu_full,
    output logic [$clog2(DEPTH):0]   _alu_count,
    output logic                     _cdb_valid,
    output logic [ROB_W-1:0]         _cdb_rob_id,
    output logic [XLEN-1:0]          _cdb_value,
    input  logic                     _cdb_grant
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int SH_W  = $clog2(XLEN);
    localparam int DC_W  = $clog2(XLEN) + 1;
    localparam int ENT_W = ROB_W + 5 + 2 * XLEN;

    typedef enum logic [1:0] {IDLE = 2'd0, DIV_BUSY = 2'd1, DIV_DONE = 2'd2} div_state_e;

    logic [ENT_W-1:0] fifo_q [DEPTH];
    logic [ENT_W-1:0] fifo_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             full_q, full_d;
    logic             cdb_valid_q, cdb_valid_d;
    logic [ROB_W-1:0] cdb_rob_q, cdb_rob_d;
    logic [XLEN-1:0]  cdb_value_q, cdb_value_d;
    div_state_e       div_state_q, div_state_d;
    logic [DC_W-1:0]  div_cnt_q, div_cnt_d;
    logic [XLEN-1:0]  div_quo_q, div_quo_d, div_rem_q, div_rem_d, div_dvs_q, div_dvs_d;
    logic             div_neg_q_q, div_neg_q_d, div_neg_r_q, div_neg_r_d;
    logic             div_is_rem_q, div_is_rem_d;
    logic [ROB_W-1:0] div_rob_q, div_rob_d;

    logic [ROB_W-1:0]  h_rob;
    logic [4:0]        h_op;
    logic [XLEN-1:0]   h_v1, h_v2;
    logic [XLEN-1:0]   alu_res, div_q_fin, div_r_fin;
    logic [2*XLEN-1:0] mul_a, mul_b, mul_p;
    logic [XLEN:0]     rem_sh;
    logic              h_is_div, h_div_signed, h_div_zero, h_div_ovf, h_special;
    logic              enq, deq, out_free, rem_ge;

    assign {h_rob, h_op, h_v1, h_v2} = fifo_q[rd_ptr_q];

    assign h_is_div     = (h_op[4:2] == 3'b101);
    assign h_div_signed = !h_op[0];
    assign h_div_zero   = (h_v2 == '0);
    assign h_div_ovf    = h_div_signed && (h_v1 == {1'b1, {(XLEN-1){1'b0}}}) && (h_v2 == '1);
    assign h_special    = h_div_zero || h_div_ovf;

    assign rem_sh    = {div_rem_q, div_quo_q[XLEN-1]};
    assign rem_ge    = (rem_sh >= {1'b0, div_dvs_q});
    assign div_q_fin = div_neg_q_q ? -div_quo_q : div_quo_q;
    assign div_r_fin = div_neg_r_q ? -div_rem_q : div_rem_q;

    // Single-cycle result for the FIFO head, including divide special cases.
    always_comb begin
        alu_res = '0;
        mul_a   = {{XLEN{(h_op == 5'd17 || h_op == 5'd18) && h_v1[XLEN-1]}}, h_v1};
        mul_b   = {{XLEN{(h_op == 5'd17) && h_v2[XLEN-1]}}, h_v2};
        mul_p   = mul_a * mul_b;
        case (h_op)
            5'd0:  alu_res = h_v1 + h_v2;
            5'd1:  alu_res = h_v1 - h_v2;
            5'd2:  alu_res = h_v1 & h_v2;
            5'd3:  alu_res = h_v1 | h_v2;
            5'd4:  alu_res = h_v1 ^ h_v2;
            5'd5:  alu_res = h_v1 << h_v2[SH_W-1:0];
            5'd6:  alu_res = h_v1 >> h_v2[SH_W-1:0];
            5'd7:  alu_res = $signed(h_v1) >>> h_v2[SH_W-1:0];
            5'd8, 5'd12: alu_res[0] = $signed(h_v1) < $signed(h_v2);
            5'd9, 5'd14: alu_res[0] = h_v1 < h_v2;
            5'd10: alu_res[0] = h_v1 == h_v2;
            5'd11: alu_res[0] = h_v1 != h_v2;
            5'd13: alu_res[0] = $signed(h_v1) >= $signed(h_v2);
            5'd15: alu_res[0] = h_v1 >= h_v2;
            5'd16: alu_res = mul_p[XLEN-1:0];
            5'd17, 5'd18, 5'd19: alu_res = mul_p[2*XLEN-1:XLEN];
            5'd20, 5'd21: alu_res = h_div_zero ? '1 : h_v1;
            5'd22, 5'd23: alu_res = h_div_zero ? h_v1 : '0;
            default: alu_res = '0;
        endcase
    end

    // Next-state for FIFO, output register and divider FSM; everything holds while rdy_in is low.
    always_comb begin
        fifo_d       = fifo_q;
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        count_d      = count_q;
        full_d       = full_q;
        cdb_valid_d  = cdb_valid_q;
        cdb_rob_d    = cdb_rob_q;
        cdb_value_d  = cdb_value_q;
        div_state_d  = div_state_q;
        div_cnt_d    = div_cnt_q;
        div_quo_d    = div_quo_q;
        div_rem_d    = div_rem_q;
        div_dvs_d    = div_dvs_q;
        div_neg_q_d  = div_neg_q_q;
        div_neg_r_d  = div_neg_r_q;
        div_is_rem_d = div_is_rem_q;
        div_rob_d    = div_rob_q;
        enq          = 1'b0;
        deq          = 1'b0;
        out_free     = !cdb_valid_q || _cdb_grant;
        if (rdy_in) begin
            if (cdb_valid_q && _cdb_grant) cdb_valid_d = 1'b0;
            case (div_state_q)
                IDLE: begin
                    if (count_q != '0) begin
                        if (h_is_div && !h_special) begin
                            deq          = 1'b1;
                            div_state_d  = DIV_BUSY;
                            div_cnt_d    = DC_W'(XLEN);
                            div_quo_d    = (h_div_signed && h_v1[XLEN-1]) ? -h_v1 : h_v1;
                            div_dvs_d    = (h_div_signed && h_v2[XLEN-1]) ? -h_v2 : h_v2;
                            div_rem_d    = '0;
                            div_neg_q_d  = h_div_signed && (h_v1[XLEN-1] ^ h_v2[XLEN-1]);
                            div_neg_r_d  = h_div_signed && h_v1[XLEN-1];
                            div_is_rem_d = h_op[1];
                            div_rob_d    = h_rob;
                        end else if (out_free) begin
                            deq         = 1'b1;
                            cdb_valid_d = 1'b1;
                            cdb_rob_d   = h_rob;
                            cdb_value_d = alu_res;
                        end
                    end
                end
                DIV_BUSY: begin
                    div_quo_d = {div_quo_q[XLEN-2:0], rem_ge};
                    div_rem_d = rem_ge ? XLEN'(rem_sh - {1'b0, div_dvs_q}) : rem_sh[XLEN-1:0];
                    div_cnt_d = div_cnt_q - 1'b1;
                    if (div_cnt_q == DC_W'(1)) div_state_d = DIV_DONE;
                end
                DIV_DONE: begin
                    if (out_free) begin
                        cdb_valid_d = 1'b1;
                        cdb_rob_d   = div_rob_q;
                        cdb_value_d = div_is_rem_q ? div_r_fin : div_q_fin;
                        div_state_d = IDLE;
                    end
                end
                default: div_state_d = IDLE;
            endcase
            enq = _alu_valid && !full_q;
            if (enq) begin
                fifo_d[wr_ptr_q] = {_alu_rob_id, _alu_op, _alu_v1, _alu_v2};
                wr_ptr_d         = wr_ptr_q + 1'b1;
            end
            if (deq) rd_ptr_d = rd_ptr_q + 1'b1;
            if (enq && !deq)      count_d = count_q + 1'b1;
            else if (!enq && deq) count_d = count_q - 1'b1;
            full_d = (count_d == CNT_W'(DEPTH));
        end
    end

    // Control and datapath registers; reset clears everything, flush clears queue, divider and valid.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            full_q       <= 1'b0;
            cdb_valid_q  <= 1'b0;
            cdb_rob_q    <= '0;
            cdb_value_q  <= '0;
            div_state_q  <= IDLE;
            div_cnt_q    <= '0;
            div_quo_q    <= '0;
            div_rem_q    <= '0;
            div_dvs_q    <= '0;
            div_neg_q_q  <= 1'b0;
            div_neg_r_q  <= 1'b0;
            div_is_rem_q <= 1'b0;
            div_rob_q    <= '0;
        end else if (_clear) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            full_q      <= 1'b0;
            cdb_valid_q <= 1'b0;
            div_state_q <= IDLE;
            div_cnt_q   <= '0;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            full_q       <= full_d;
            cdb_valid_q  <= cdb_valid_d;
            cdb_rob_q    <= cdb_rob_d;
            cdb_value_q  <= cdb_value_d;
            div_state_q  <= div_state_d;
            div_cnt_q    <= div_cnt_d;
            div_quo_q    <= div_quo_d;
            div_rem_q    <= div_rem_d;
            div_dvs_q    <= div_dvs_d;
            div_neg_q_q  <= div_neg_q_d;
            div_neg_r_q  <= div_neg_r_d;
            div_is_rem_q <= div_is_rem_d;
            div_rob_q    <= div_rob_d;
        end
    end

    // FIFO storage; entries are only meaningful between the pointers, so no reset is needed.
    always_ff @(posedge clk_in) begin
        fifo_q <= fifo_d;
    end

    assign _alu_full   = full_q;
    assign _alu_count  = count_q;
    assign _cdb_valid  = cdb_valid_q;
    assign _cdb_rob_id = cdb_rob_q;
    assign _cdb_value  = cdb_value_q;

endmodule

// File: tb/tb_alu_pipe.sv
// Directed bench for alu_pipe: single-cycle ops, divider latency and special
// cases, CDB back-pressure with a full FIFO, flush, and rdy_in freeze.
module tb_alu_pipe;

    localparam int XLEN  = 32;
    localparam int ROB_W = 5;
    localparam int DEPTH = 4;

    logic              clk = 1'b0;
    logic              rst, rdy, clear, alu_valid, grant;
    logic [ROB_W-1:0]  rob_id;
    logic [4:0]        op;
    logic [XLEN-1:0]   v1, v2;
    logic              full, cdb_valid;
    logic [$clog2(DEPTH):0] count;
    logic [ROB_W-1:0]  cdb_rob;
    logic [XLEN-1:0]   cdb_value;

    int checks = 0;
    int errors = 0;
    bit flag;

    alu_pipe #(.XLEN(XLEN), .ROB_W(ROB_W), .DEPTH(DEPTH)) dut (
        .clk_in(clk), .rst_in(rst), .rdy_in(rdy), ._clear(clear),
        ._alu_valid(alu_valid), ._alu_rob_id(rob_id), ._alu_op(op),
        ._alu_v1(v1), ._alu_v2(v2), ._alu_full(full), ._alu_count(count),
        ._cdb_valid(cdb_valid), ._cdb_rob_id(cdb_rob), ._cdb_value(cdb_value),
        ._cdb_grant(grant)
    );

    always #5 clk = ~clk;

    // one active edge, then return at the following falling edge
    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic [4:0] o, input logic [ROB_W-1:0] r,
                         input logic [XLEN-1:0] a, input logic [XLEN-1:0] b);
        alu_valid = 1'b1; op = o; rob_id = r; v1 = a; v2 = b;
    endtask

    // issue one op into an empty pipe with grant high; lat = edges after the accept edge
    task automatic run_op(input string tag, input logic [4:0] o, input logic [ROB_W-1:0] r,
                          input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                          input logic [XLEN-1:0] exp, input int exp_lat);
        int n;
        drive(o, r, a, b);
        step();
        alu_valid = 1'b0;
        n = 0;
        while (!cdb_valid && n < 60) begin
            step();
            n++;
        end
        chk({tag, "_lat"}, n, exp_lat);
        chk({tag, "_rob"}, cdb_rob, r);
        chk({tag, "_val"}, cdb_value, exp);
        step();
    endtask

    initial begin
        rst = 1'b1; rdy = 1'b1; clear = 1'b0; alu_valid = 1'b0; grant = 1'b0;
        op = '0; rob_id = '0; v1 = '0; v2 = '0;
        step();
        step();
        chk("rst_full", full, 0);
        chk("rst_count", count, 0);
        chk("rst_valid", cdb_valid, 0);
        chk("rst_rob", cdb_rob, 0);
        chk("rst_value", cdb_value, 0);
        rst = 1'b0;

        // ADD rob 3: visible after the second edge, gone the cycle after
        grant = 1'b1;
        drive(5'd0, 5'd3, 32'd5, 32'd7);
        step();
        alu_valid = 1'b0;
        chk("add_e0_valid", cdb_valid, 0);
        chk("add_e0_count", count, 1);
        step();
        chk("add_valid", cdb_valid, 1);
        chk("add_rob", cdb_rob, 3);
        chk("add_value", cdb_value, 12);
        chk("add_count", count, 0);
        step();
        chk("add_drop", cdb_valid, 0);

        // SRA then SLTU back to back
        drive(5'd7, 5'd1, 32'h8000_0000, 32'h21);
        step();
        drive(5'd9, 5'd2, 32'd1, 32'hFFFF_FFFF);
        step();
        alu_valid = 1'b0;
        chk("sra_rob", cdb_rob, 1);
        chk("sra_value", cdb_value, 32'hC000_0000);
        step();
        chk("sltu_valid", cdb_valid, 1);
        chk("sltu_rob", cdb_rob, 2);
        chk("sltu_value", cdb_value, 1);
        step();
        chk("sltu_drop", cdb_valid, 0);

        // DIV -7/2 then ADD: the quotient appears at E34 and precedes the sum
        drive(5'd20, 5'd4, -32'sd7, 32'd2);
        step();
        drive(5'd0, 5'd9, 32'd1, 32'd1);
        step();
        alu_valid = 1'b0;
        flag = 1'b0;
        for (int i = 0; i < 32; i++) begin
            if (cdb_valid) flag = 1'b1;
            step();
        end
        chk("div_early", flag, 0);
        chk("div_busy_count", count, 1);
        step();
        chk("div_valid", cdb_valid, 1);
        chk("div_rob", cdb_rob, 4);
        chk("div_value", cdb_value, 32'hFFFF_FFFD);
        step();
        chk("div_add_rob", cdb_rob, 9);
        chk("div_add_value", cdb_value, 2);
        step();
        chk("div_add_drop", cdb_valid, 0);

        run_op("divu_zero", 5'd21, 5'd5, 32'h1234, 32'd0, 32'hFFFF_FFFF, 1);
        run_op("rem_ovf", 5'd22, 5'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1);
        run_op("div_ovf", 5'd20, 5'd7, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1);
        run_op("rem_zero", 5'd23, 5'd8, 32'd77, 32'd0, 32'd77, 1);
        run_op("rem_neg", 5'd22, 5'd10, -32'sd7, 32'd2, 32'hFFFF_FFFF, 34);
        run_op("remu", 5'd23, 5'd11, 32'd100, 32'd7, 32'd2, 34);
        run_op("divu_big", 5'd21, 5'd12, 32'hFFFF_FFFF, 32'h10, 32'h0FFF_FFFF, 34);
        run_op("div_pos_neg", 5'd20, 5'd13, 32'd100, -32'sd7, -32'sd14, 34);
        run_op("sub", 5'd1, 5'd14, 32'd5, 32'd7, 32'hFFFF_FFFE, 1);
        run_op("sll", 5'd5, 5'd15, 32'd1, 32'h3F, 32'h8000_0000, 1);
        run_op("blt", 5'd12, 5'd16, 32'hFFFF_FFFF, 32'd1, 32'd1, 1);
        run_op("bgeu", 5'd15, 5'd17, 32'd1, 32'hFFFF_FFFF, 32'd0, 1);
        run_op("mul", 5'd16, 5'd18, 32'd6, 32'hFFFF_FFF9, 32'hFFFF_FFD6, 1);
        run_op("mulh", 5'd17, 5'd19, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 1);
        run_op("mulhsu", 5'd18, 5'd20, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1);
        run_op("op25", 5'd25, 5'd21, 32'd3, 32'd4, 32'd0, 1);

        // back-pressure: grant low, the first op sits in the output register, four fill the FIFO
        grant = 1'b0;
        for (int i = 0; i < 5; i++) begin
            drive(5'd0, 5'(10 + i), 32'(10 + i), 32'd100);
            step();
        end
        chk("bp_full", full, 1);
        chk("bp_count", count, 4);
        drive(5'd0, 5'd15, 32'd15, 32'd100);
        step();
        chk("bp_refused", count, 4);
        chk("bp_hold_rob", cdb_rob, 10);
        chk("bp_hold_value", cdb_value, 110);
        grant = 1'b1;
        step();
        chk("bp_d1_rob", cdb_rob, 11);
        chk("bp_d1_count", count, 3);
        step();
        alu_valid = 1'b0;
        chk("bp_d2_rob", cdb_rob, 12);
        chk("bp_d2_count", count, 3);
        for (int i = 13; i <= 15; i++) begin
            step();
            chk("bp_drain_rob", cdb_rob, i);
            chk("bp_drain_value", cdb_value, i + 100);
        end
        chk("bp_empty", count, 0);
        step();
        chk("bp_drop", cdb_valid, 0);

        // flush mid-divide together with a new issue
        drive(5'd20, 5'd20, 32'd100, 32'd7);
        step();
        alu_valid = 1'b0;
        for (int i = 0; i < 6; i++) step();
        clear = 1'b1;
        drive(5'd0, 5'd21, 32'd1, 32'd2);
        step();
        clear = 1'b0;
        alu_valid = 1'b0;
        chk("clr_valid", cdb_valid, 0);
        chk("clr_count", count, 0);
        chk("clr_full", full, 0);
        flag = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (cdb_valid) flag = 1'b1;
            step();
        end
        chk("clr_stale", flag, 0);
        run_op("clr_after", 5'd0, 5'd22, 32'd3, 32'd4, 32'd7, 1);

        // rdy_in low freezes a pending MUL and a queued MULHU
        grant = 1'b0;
        drive(5'd16, 5'd23, 32'd6, 32'd7);
        step();
        drive(5'd19, 5'd24, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        step();
        chk("rdy_mul_value", cdb_value, 42);
        chk("rdy_pre_count", count, 1);
        rdy = 1'b0;
        grant = 1'b1;
        drive(5'd0, 5'd25, 32'd1, 32'd1);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("frz_valid", cdb_valid, 1);
            chk("frz_rob", cdb_rob, 23);
            chk("frz_value", cdb_value, 42);
            chk("frz_count", count, 1);
        end
        alu_valid = 1'b0;
        rdy = 1'b1;
        step();
        chk("mulhu_rob", cdb_rob, 24);
        chk("mulhu_value", cdb_value, 32'hFFFF_FFFE);
        step();
        chk("mulhu_drop", cdb_valid, 0);
        chk("end_count", count, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
